// File: rtl/debug_unit.sv
`timescale 1ns/1ps
// Host debug controller: UART commands load imem, run/step the pipeline, then stream PC/regs/dmem back.
// Registered outputs; one tx byte in flight at a time, each held until i_tx_done acknowledges it.
module debug_unit #(
    parameter int INST_SZ   = 32,
    parameter int BYTE_SZ   = 8,
    parameter int REG_SZ    = 5,
    parameter int N_REGS    = 32,
    parameter int N_MEM     = 32,
    parameter logic [INST_SZ-1:0] HALT_INST = 32'h0000_003F
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [INST_SZ-1:0] i_pc,
    input  logic [INST_SZ-1:0] i_reg,
    input  logic [INST_SZ-1:0] i_mem,
    input  logic               i_halt,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_enable,
    output logic [REG_SZ-1:0]  o_debug_addr,
    output logic [BYTE_SZ-1:0] o_tx_data,
    output logic               o_tx_start
);

    localparam int BPW  = INST_SZ / BYTE_SZ;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [BYTE_SZ-1:0] CMD_LOAD = BYTE_SZ'(8'h4C);
    localparam logic [BYTE_SZ-1:0] CMD_RUN  = BYTE_SZ'(8'h52);
    localparam logic [BYTE_SZ-1:0] CMD_STEP = BYTE_SZ'(8'h53);
    localparam logic [BYTE_SZ-1:0] CMD_DUMP = BYTE_SZ'(8'h44);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD       = 4'd1;
    localparam logic [3:0] S_LOAD_WR    = 4'd2;
    localparam logic [3:0] S_RUN        = 4'd3;
    localparam logic [3:0] S_STEP       = 4'd4;
    localparam logic [3:0] S_STEP_END   = 4'd5;
    localparam logic [3:0] S_DUMP_ADDR  = 4'd6;
    localparam logic [3:0] S_DUMP_WAIT  = 4'd7;
    localparam logic [3:0] S_DUMP_LATCH = 4'd8;
    localparam logic [3:0] S_DUMP_SEND  = 4'd9;
    localparam logic [3:0] S_DUMP_ACK   = 4'd10;

    // Dump word counter: section (PC, registers, memory) plus index within the section.
    localparam logic [1:0] SEC_PC  = 2'd0;
    localparam logic [1:0] SEC_REG = 2'd1;
    localparam logic [1:0] SEC_MEM = 2'd2;

    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BPW - 1);
    localparam logic [REG_SZ-1:0] LAST_REG  = REG_SZ'(N_REGS - 1);
    localparam logic [REG_SZ-1:0] LAST_MEM  = REG_SZ'(N_MEM - 1);

    logic [3:0]         state;
    logic [BC_W-1:0]    byte_cnt;
    logic [1:0]         sec;
    logic [REG_SZ-1:0]  idx;
    logic [INST_SZ-1:0] shift;
    logic [INST_SZ-1:0] rd_word;
    logic [INST_SZ-1:0] load_word;
    logic               last_word;

    always_comb begin
        rd_word = i_mem;
        if (sec == SEC_PC) begin
            rd_word = i_pc;
        end else if (sec == SEC_REG) begin
            rd_word = i_reg;
        end
    end

    assign load_word = {shift[INST_SZ-BYTE_SZ-1:0], i_rx_data};
    assign last_word = (sec == SEC_MEM) && (idx == LAST_MEM);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            byte_cnt      <= '0;
            sec           <= SEC_PC;
            idx           <= '0;
            shift         <= '0;
            o_write       <= 1'b0;
            o_instruction <= '0;
            o_enable      <= 1'b0;
            o_debug_addr  <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
        end else begin
            o_write    <= 1'b0;
            o_tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                state    <= S_LOAD;
                                byte_cnt <= '0;
                                shift    <= '0;
                            end
                            CMD_RUN:  state <= S_RUN;
                            CMD_STEP: state <= S_STEP;
                            CMD_DUMP: state <= S_DUMP_ADDR;
                            default:  state <= S_IDLE;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (i_rx_done) begin
                        shift    <= load_word;
                        byte_cnt <= byte_cnt + BC_W'(1);
                        if (byte_cnt == LAST_BYTE) begin
                            o_write       <= 1'b1;
                            o_instruction <= load_word;
                            state         <= S_LOAD_WR;
                        end
                    end
                end
                S_LOAD_WR: begin
                    byte_cnt <= '0;
                    state    <= (o_instruction == HALT_INST) ? S_IDLE : S_LOAD;
                end
                S_RUN: begin
                    if (i_halt) begin
                        o_enable <= 1'b0;
                        state    <= S_DUMP_ADDR;
                    end else begin
                        o_enable <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (i_halt) begin
                        state <= S_DUMP_ADDR;
                    end else begin
                        o_enable <= 1'b1;
                        state    <= S_STEP_END;
                    end
                end
                S_STEP_END: begin
                    o_enable <= 1'b0;
                    state    <= S_DUMP_ADDR;
                end
                S_DUMP_ADDR: begin
                    o_debug_addr <= idx;
                    state        <= S_DUMP_WAIT;
                end
                // Extra cycle lets a registered-read memory settle before the latch.
                S_DUMP_WAIT: state <= S_DUMP_LATCH;
                S_DUMP_LATCH: begin
                    shift    <= rd_word;
                    byte_cnt <= '0;
                    state    <= S_DUMP_SEND;
                end
                S_DUMP_SEND: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= shift[INST_SZ-1 -: BYTE_SZ];
                    state      <= S_DUMP_ACK;
                end
                S_DUMP_ACK: begin
                    if (i_tx_done) begin
                        shift <= {shift[INST_SZ-BYTE_SZ-1:0], {BYTE_SZ{1'b0}}};
                        if (byte_cnt != LAST_BYTE) begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                            state    <= S_DUMP_SEND;
                        end else begin
                            byte_cnt <= '0;
                            if (last_word) begin
                                sec          <= SEC_PC;
                                idx          <= '0;
                                o_debug_addr <= '0;
                                state        <= S_IDLE;
                            end else begin
                                state <= S_DUMP_ADDR;
                                if (sec == SEC_PC) begin
                                    sec <= SEC_REG;
                                    idx <= '0;
                                end else if (sec == SEC_REG && idx == LAST_REG) begin
                                    sec <= SEC_MEM;
                                    idx <= '0;
                                end else begin
                                    idx <= idx + REG_SZ'(1);
                                end
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
